// File: rtl/io_bridge_if.sv
// CPU byte-bus and UART stream signals of the io_bridge memory-mapped endpoint.
interface io_bridge_if;
  logic        rdy_in;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  io_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_done;
  logic        tx_overflow;

  modport slave (
    input  rdy_in, cpu_a, cpu_wr, cpu_dout, tx_ready, rx_data, rx_valid,
    output io_din, io_buffer_full, tx_data, tx_valid, rx_ready, program_done, tx_overflow
  );

  modport master (
    output rdy_in, cpu_a, cpu_wr, cpu_dout, tx_ready, rx_data, rx_valid,
    input  io_din, io_buffer_full, tx_data, tx_valid, rx_ready, program_done, tx_overflow
  );
endinterface

// File: rtl/io_bridge.sv
// Memory-mapped I/O endpoint: UART TX/RX FIFOs, free-running cycle counter and
// program-stop flag, decoded at cpu_a[17:16]==2'b11 with one-cycle read latency.
module io_bridge #(
  parameter int unsigned TX_WIDTH = 4,
  parameter int unsigned RX_WIDTH = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  io_bridge_if.slave bus
);
  localparam int unsigned TX_DEPTH = 1 << TX_WIDTH;
  localparam int unsigned RX_DEPTH = 1 << RX_WIDTH;
  localparam int unsigned TXC_W    = TX_WIDTH + 1;
  localparam int unsigned RXC_W    = RX_WIDTH + 1;

  logic [7:0]          tx_mem_q [TX_DEPTH];
  logic [7:0]          tx_mem_d [TX_DEPTH];
  logic [TX_WIDTH-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [TXC_W-1:0]    tx_count_q, tx_count_d;
  logic [7:0]          rx_mem_q [RX_DEPTH];
  logic [7:0]          rx_mem_d [RX_DEPTH];
  logic [RX_WIDTH-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RXC_W-1:0]    rx_count_q, rx_count_d;
  logic                rx_ready_q, rx_ready_d;
  logic [31:0]         cnt_q, cnt_d, snap_q, snap_d;
  logic [7:0]          io_din_q, io_din_d;
  logic                done_pending_q, done_pending_d;
  logic                program_done_q, program_done_d;
  logic                tx_overflow_q, tx_overflow_d;

  logic       acc, wr0, wr4, rd, tx_full, tx_pop, cpu_push, done_push, tx_push;
  logic       rx_push, rx_pop;
  logic [2:0] off;
  logic [7:0] tx_wdata;
  logic       unused_addr;

  assign acc       = bus.rdy_in & (bus.cpu_a[17:16] == 2'b11);
  assign off       = bus.cpu_a[2:0];
  assign wr0       = acc & bus.cpu_wr & (off == 3'd0) & (bus.cpu_dout != 8'h00);
  assign wr4       = acc & bus.cpu_wr & (off == 3'd4);
  assign rd        = acc & ~bus.cpu_wr;
  assign tx_full   = tx_count_q == TXC_W'(TX_DEPTH);
  assign tx_pop    = (tx_count_q != '0) & bus.tx_ready;
  assign cpu_push  = wr0 & (~tx_full | tx_pop);
  // The stop marker only takes a slot the CPU is not using this cycle.
  assign done_push = done_pending_q & ~cpu_push & (~tx_full | tx_pop);
  assign tx_push   = cpu_push | done_push;
  assign tx_wdata  = cpu_push ? bus.cpu_dout : 8'h00;
  assign rx_push   = bus.rx_valid & rx_ready_q;
  assign rx_pop    = rd & (off == 3'd0) & (rx_count_q != '0);
  assign unused_addr = ^{bus.cpu_a[31:18], bus.cpu_a[15:3]};

  // Next-state for FIFOs, flags and counter.
  always_comb begin
    tx_mem_d       = tx_mem_q;
    tx_wptr_d      = tx_wptr_q;
    tx_rptr_d      = tx_rptr_q;
    rx_mem_d       = rx_mem_q;
    rx_wptr_d      = rx_wptr_q;
    rx_rptr_d      = rx_rptr_q;
    cnt_d          = cnt_q + 32'd1;
    tx_overflow_d  = tx_overflow_q | (wr0 & tx_full & ~tx_pop);
    program_done_d = program_done_q | wr4;
    done_pending_d = (done_pending_q & ~done_push) | wr4;
    if (tx_push) begin
      tx_mem_d[tx_wptr_q] = tx_wdata;
      tx_wptr_d           = tx_wptr_q + TX_WIDTH'(1);
    end
    if (tx_pop) tx_rptr_d = tx_rptr_q + TX_WIDTH'(1);
    if (rx_push) begin
      rx_mem_d[rx_wptr_q] = bus.rx_data;
      rx_wptr_d           = rx_wptr_q + RX_WIDTH'(1);
    end
    if (rx_pop) rx_rptr_d = rx_rptr_q + RX_WIDTH'(1);
    tx_count_d = tx_count_q + TXC_W'(tx_push) - TXC_W'(tx_pop);
    rx_count_d = rx_count_q + RXC_W'(rx_push) - RXC_W'(rx_pop);
    rx_ready_d = rx_count_d != RXC_W'(RX_DEPTH);
  end

  // Read data path; offset 4 snapshots the counter so 4..7 reads are coherent.
  always_comb begin
    io_din_d = io_din_q;
    snap_d   = snap_q;
    if (bus.rdy_in) begin
      io_din_d = 8'h00;
      if (rd) begin
        case (off)
          3'd0:    if (rx_count_q != '0) io_din_d = rx_mem_q[rx_rptr_q];
          3'd4:    begin io_din_d = cnt_q[7:0]; snap_d = cnt_q; end
          3'd5:    io_din_d = snap_q[15:8];
          3'd6:    io_din_d = snap_q[23:16];
          3'd7:    io_din_d = snap_q[31:24];
          default: io_din_d = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < int'(TX_DEPTH); i++) tx_mem_q[i] <= 8'h00;
      for (int i = 0; i < int'(RX_DEPTH); i++) rx_mem_q[i] <= 8'h00;
      tx_wptr_q      <= '0;
      tx_rptr_q      <= '0;
      tx_count_q     <= '0;
      rx_wptr_q      <= '0;
      rx_rptr_q      <= '0;
      rx_count_q     <= '0;
      rx_ready_q     <= 1'b0;
      cnt_q          <= 32'd0;
      snap_q         <= 32'd0;
      io_din_q       <= 8'h00;
      done_pending_q <= 1'b0;
      program_done_q <= 1'b0;
      tx_overflow_q  <= 1'b0;
    end else begin
      tx_mem_q       <= tx_mem_d;
      rx_mem_q       <= rx_mem_d;
      tx_wptr_q      <= tx_wptr_d;
      tx_rptr_q      <= tx_rptr_d;
      tx_count_q     <= tx_count_d;
      rx_wptr_q      <= rx_wptr_d;
      rx_rptr_q      <= rx_rptr_d;
      rx_count_q     <= rx_count_d;
      rx_ready_q     <= rx_ready_d;
      cnt_q          <= cnt_d;
      snap_q         <= snap_d;
      io_din_q       <= io_din_d;
      done_pending_q <= done_pending_d;
      program_done_q <= program_done_d;
      tx_overflow_q  <= tx_overflow_d;
    end
  end

  assign bus.io_din         = io_din_q;
  assign bus.tx_data        = tx_mem_q[tx_rptr_q];
  assign bus.tx_valid       = tx_count_q != '0;
  assign bus.io_buffer_full = tx_count_q >= TXC_W'(TX_DEPTH - 2);
  assign bus.rx_ready       = rx_ready_q;
  assign bus.program_done   = program_done_q;
  assign bus.tx_overflow    = tx_overflow_q;
endmodule

// File: doc/io_bridge.md
Name: io_bridge

Overview:
- Memory-mapped I/O endpoint on the CPU's external byte bus, directly downstream of the cpu top.
- Decodes accesses with mem_a[17:16]==2'b11 and buffers UART output bytes in a TX FIFO and UART input bytes in an RX FIFO.
- Provides the free-running clock counter at 0x30004 and the program-stop indication.
- Generates io_buffer_full for the CPU and returns I/O read data one cycle after a read, matching RAM read latency.

Parameters:
- TX_WIDTH, 4, log2 of TX FIFO depth (16 entries)
- RX_WIDTH, 4, log2 of RX FIFO depth (16 entries)

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  CPU-side enable; CPU-side state frozen when low
- cpu_a  in  32  CPU address bus
- cpu_wr  in  1  1 = write, 0 = read
- cpu_dout  in  8  CPU write data
- io_din  out  8  I/O read data, valid the cycle after the read
- io_buffer_full  out  1  TX almost-full; CPU must not issue a 0x30000 write while high
- tx_data  out  8  TX FIFO head byte
- tx_valid  out  1  TX FIFO non-empty
- tx_ready  in  1  UART transmitter accepts tx_data
- rx_data  in  8  received byte
- rx_valid  in  1  received byte present
- rx_ready  out  1  RX FIFO not full
- program_done  out  1  sticky; set by a write to 0x30004
- tx_overflow  out  1  sticky; a TX byte was dropped

Behaviour:
- Reset (rst_in low, async): both FIFOs empty, all pointers/counts 0, cycle counter 0, done_pending 0, all outputs 0. rx_ready goes to 1 on the first clock edge after release.
- Access qualifier: acc = rdy_in & (cpu_a[17:16]==2'b11). Register offset is cpu_a[2:0]; higher bits are ignored.
- Write, offset 0 (0x30000):
  - cpu_dout==0: ignored.
  - Otherwise, push cpu_dout if the TX FIFO is not full.
  - If the TX FIFO is full: drop the byte and set tx_overflow.
- Write, offset 4 (0x30004):
  - Set program_done and done_pending.
  - While done_pending is set, push 0x00 on the first cycle the TX FIFO has space that is not taken by a same-cycle CPU push, then clear done_pending. A CPU byte wins that cycle; 0x00 follows.
- Read, offset 0: in the next cycle io_din = RX head, and the entry is popped at that edge. If the RX FIFO is empty, io_din = 0x00 and there is no pop.
- Read, offset 4..7:
  - io_din = byte cpu_a[1:0] of a 32-bit snapshot, little-endian.
  - A read at offset 4 latches snapshot = counter and returns byte 0 from the live counter value, so a 4..7 read sequence is coherent.
- Any other read, or acc low: io_din = 0x00 the next cycle.
- Cycle counter: 32-bit, increments on every clk_in independent of rdy_in, wraps 0xFFFFFFFF -> 0.
- rdy_in low:
  - No CPU-side pushes, pops, snapshots or io_din updates; io_din holds its value.
  - The UART side continues: TX drain and RX fill.
- TX FIFO:
  - tx_valid = count != 0; tx_data = head.
  - Pop on tx_valid & tx_ready.
  - Push and pop in the same cycle: count unchanged, both take effect. A push into a full FIFO with a simultaneous pop is accepted.
- io_buffer_full = (tx_count >= 2^TX_WIDTH - 2). This is combinational from the registered count and gives one cycle of slack for an in-flight write.
- RX FIFO:
  - rx_ready = count != 2^RX_WIDTH.
  - Push on rx_valid & rx_ready.
  - Simultaneous push and CPU pop: count unchanged.
  - A push into a full FIFO with a simultaneous pop is not accepted, because rx_ready is low.
- Pointers wrap modulo depth; count has width W+1.

Test Plan:
1. Reset, then write 0x41, 0x42 to 0x30000 with tx_ready=1 -> tx_data 0x41 then 0x42 on consecutive cycles; tx_valid low afterwards; tx_overflow=0.
2. tx_ready=0, write 0x00 once, then 16 nonzero bytes -> 0x00 ignored. io_buffer_full rises when count reaches 14. The 16th byte is accepted (count 16); a 17th write sets tx_overflow=1 with count still 16.
3. rx_valid pulses 0x55 then 0xAA; CPU reads 0x30000 three times -> io_din 0x55, 0xAA, 0x00 on the cycles after each read; rx_ready=1 throughout.
4. Counter at reset+100 cycles: read 0x30004..0x30007 spread over several cycles -> bytes reassemble to the value latched at the 0x30004 read, not later values. Force counter 0xFFFFFFFF -> next value 0.
5. TX FIFO full (tx_ready=0), write 0x30004 -> program_done=1 immediately. Set tx_ready=1 -> 0x00 appears after the 16 queued bytes, exactly once.
6. rdy_in=0 while cpu_wr=1 to 0x30000 and rx_valid=1 -> no TX push; RX still fills. Assert rst_in low mid-transfer -> all outputs 0 asynchronously, before the next clock edge.
